// File: rtl/mac_conv_ctrl.sv
// Sequencer for a 3-tap shift-register MAC: loads weights once per job, slides
// features one per window, and hands each MAC result out on a valid/ready port.
module mac_conv_ctrl #(
    parameter int DATA_BIT = 16,
    parameter int TAPS     = 3,
    parameter int MAC_LAT  = 1,
    parameter int CNT_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [CNT_W-1:0]        num_win,
    input  logic                    w_valid,
    output logic                    w_ready,
    input  logic [DATA_BIT-1:0]     w_data,
    input  logic                    f_valid,
    output logic                    f_ready,
    input  logic [DATA_BIT-1:0]     f_data,
    output logic                    mac_clear,
    output logic                    mac_w_w,
    output logic [DATA_BIT-1:0]     mac_w_in,
    output logic                    mac_if_w,
    output logic [DATA_BIT-1:0]     mac_if_in,
    input  logic [2*DATA_BIT+1:0]   mac_out,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [2*DATA_BIT+1:0]   res_data,
    output logic                    busy,
    output logic                    done
);

    localparam int TAP_W = $clog2(TAPS + 1);
    localparam int LAT_W = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_LOAD_W,
        S_LOAD_F,
        S_WAIT,
        S_OUT,
        S_FIN
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   rem;
    logic [TAP_W-1:0]   tap_cnt;
    logic [TAP_W-1:0]   need;
    logic [LAT_W-1:0]   wait_cnt;

    logic w_hs;
    logic f_hs;
    logic r_hs;

    // Readies are a pure decode of the state register, so they never glitch.
    assign w_ready = (state == S_LOAD_W);
    assign f_ready = (state == S_LOAD_F);

    assign w_hs = w_valid & w_ready;
    assign f_hs = f_valid & f_ready;
    assign r_hs = res_valid & res_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            rem       <= '0;
            tap_cnt   <= '0;
            need      <= '0;
            wait_cnt  <= '0;
            mac_clear <= 1'b0;
            mac_w_w   <= 1'b0;
            mac_w_in  <= '0;
            mac_if_w  <= 1'b0;
            mac_if_in <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // Strobes and their data are single-cycle; idle value is zero.
            mac_clear <= 1'b0;
            mac_w_w   <= 1'b0;
            mac_w_in  <= '0;
            mac_if_w  <= 1'b0;
            mac_if_in <= '0;
            done      <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (num_win != '0) begin
                            rem       <= num_win;
                            mac_clear <= 1'b1;
                            state     <= S_CLR;
                        end else begin
                            done  <= 1'b1;
                            state <= S_FIN;
                        end
                    end
                end

                S_CLR: begin
                    tap_cnt <= '0;
                    state   <= S_LOAD_W;
                end

                S_LOAD_W: begin
                    if (w_hs) begin
                        mac_w_w  <= 1'b1;
                        mac_w_in <= w_data;
                        tap_cnt  <= tap_cnt + TAP_W'(1);
                        if (tap_cnt == TAP_W'(TAPS - 1)) begin
                            need  <= TAP_W'(TAPS);
                            state <= S_LOAD_F;
                        end
                    end
                end

                S_LOAD_F: begin
                    if (f_hs) begin
                        mac_if_w  <= 1'b1;
                        mac_if_in <= f_data;
                        need      <= need - TAP_W'(1);
                        if (need == TAP_W'(1)) begin
                            wait_cnt <= '0;
                            state    <= S_WAIT;
                        end
                    end
                end

                // First WAIT cycle coincides with the last feature strobe.
                S_WAIT: begin
                    if (wait_cnt == LAT_W'(MAC_LAT)) begin
                        res_data  <= mac_out;
                        res_valid <= 1'b1;
                        state     <= S_OUT;
                    end else begin
                        wait_cnt <= wait_cnt + LAT_W'(1);
                    end
                end

                S_OUT: begin
                    if (r_hs) begin
                        res_valid <= 1'b0;
                        rem       <= rem - CNT_W'(1);
                        if (rem == CNT_W'(1)) begin
                            done  <= 1'b1;
                            state <= S_FIN;
                        end else begin
                            need  <= TAP_W'(1);
                            state <= S_LOAD_F;
                        end
                    end
                end

                S_FIN: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_conv_ctrl.sv
// Directed bench for mac_conv_ctrl: cycle table for a single window plus
// sequences for sliding, backpressure, stream gaps, degenerate jobs and reset.
module tb_mac_conv_ctrl;

    localparam int DB = 16;
    localparam int CW = 16;
    localparam int RW = 2 * DB + 2;
    localparam logic [RW-1:0] BASE = 34'h2_0000_0100;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] num_win = '0;
    logic          w_valid = 1'b0;
    logic          w_ready;
    logic [DB-1:0] w_data = '0;
    logic          f_valid = 1'b0;
    logic          f_ready;
    logic [DB-1:0] f_data = '0;
    logic          mac_clear;
    logic          mac_w_w;
    logic [DB-1:0] mac_w_in;
    logic          mac_if_w;
    logic [DB-1:0] mac_if_in;
    logic [RW-1:0] mac_out = '0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [RW-1:0] res_data;
    logic          busy;
    logic          done;

    mac_conv_ctrl #(.DATA_BIT(DB), .TAPS(3), .MAC_LAT(1), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .num_win(num_win),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .f_valid(f_valid), .f_ready(f_ready), .f_data(f_data),
        .mac_clear(mac_clear), .mac_w_w(mac_w_w), .mac_w_in(mac_w_in),
        .mac_if_w(mac_if_w), .mac_if_in(mac_if_in), .mac_out(mac_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    logic [DB-1:0] wts [0:7];
    logic [DB-1:0] fts [0:15];
    int widx, fidx, wsidx, fsidx, clr_cnt;
    logic [63:0] w_mask, f_mask, r_mask;

    typedef struct {
        int           c;
        logic         clr;
        logic         ww;
        logic [15:0]  wd;
        logic         fw;
        logic [15:0]  fd;
        logic         rv;
        logic         dn;
        logic         bz;
        logic         wr;
        logic         fr;
    } vec_t;

    vec_t tab [13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic drive();
        w_valid   = (cyc < 64) ? w_mask[cyc] : 1'b1;
        w_data    = (widx < 8) ? wts[widx] : '0;
        f_valid   = (cyc < 64) ? f_mask[cyc] : 1'b1;
        f_data    = (fidx < 16) ? fts[fidx] : '0;
        res_ready = (cyc < 64) ? r_mask[cyc] : 1'b1;
        mac_out   = BASE + RW'(cyc);
    endtask

    // One clock: note handshakes the edge will see, advance, then monitor strobe order.
    task automatic tick();
        bit whs, fhs;
        whs = w_valid && w_ready;
        fhs = f_valid && f_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (whs) widx++;
        if (fhs) fidx++;
        if (mac_clear) clr_cnt++;
        if (mac_w_w) begin
            check("w_order", 64'(mac_w_in), 64'((wsidx < 8) ? wts[wsidx] : 16'h0));
            wsidx++;
        end
        if (mac_if_w) begin
            check("f_order", 64'(mac_if_in), 64'((fsidx < 16) ? fts[fsidx] : 16'h0));
            fsidx++;
        end
        start = 1'b0;
        drive();
    endtask

    task automatic reset_masks();
        w_mask = '1;
        f_mask = '1;
        r_mask = '1;
    endtask

    task automatic start_job(input int n);
        cyc = 0;
        widx = 0; fidx = 0; wsidx = 0; fsidx = 0; clr_cnt = 0;
        num_win = CW'(n);
        drive();
        start = 1'b1;
        $display("[TB] job start num_win=%0d", n);
    endtask

    task automatic check_zero(input string name);
        check({name, "_flags"},
              64'({busy, done, res_valid, mac_clear, mac_w_w, mac_if_w, w_ready, f_ready}), 64'd0);
        check({name, "_res_data"}, 64'(res_data), 64'd0);
        check({name, "_mac_data"}, 64'({mac_w_in, mac_if_in}), 64'd0);
    endtask

    task automatic check_counts(input string name, input int w, input int f, input int c);
        check(name, 64'({8'(widx), 8'(wsidx), 8'(fidx), 8'(fsidx), 8'(clr_cnt)}),
              64'({8'(w), 8'(w), 8'(f), 8'(f), 8'(c)}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] ww_cycles;
        bit seen_done;

        tab[0]  = '{0,  0, 0, 16'd0, 0, 16'd0, 0, 0, 0, 0, 0};
        tab[1]  = '{1,  1, 0, 16'd0, 0, 16'd0, 0, 0, 1, 0, 0};
        tab[2]  = '{2,  0, 0, 16'd0, 0, 16'd0, 0, 0, 1, 1, 0};
        tab[3]  = '{3,  0, 1, 16'd1, 0, 16'd0, 0, 0, 1, 1, 0};
        tab[4]  = '{4,  0, 1, 16'd2, 0, 16'd0, 0, 0, 1, 1, 0};
        tab[5]  = '{5,  0, 1, 16'd3, 0, 16'd0, 0, 0, 1, 0, 1};
        tab[6]  = '{6,  0, 0, 16'd0, 1, 16'd4, 0, 0, 1, 0, 1};
        tab[7]  = '{7,  0, 0, 16'd0, 1, 16'd5, 0, 0, 1, 0, 1};
        tab[8]  = '{8,  0, 0, 16'd0, 1, 16'd6, 0, 0, 1, 0, 0};
        tab[9]  = '{9,  0, 0, 16'd0, 0, 16'd0, 0, 0, 1, 0, 0};
        tab[10] = '{10, 0, 0, 16'd0, 0, 16'd0, 1, 0, 1, 0, 0};
        tab[11] = '{11, 0, 0, 16'd0, 0, 16'd0, 0, 1, 1, 0, 0};
        tab[12] = '{12, 0, 0, 16'd0, 0, 16'd0, 0, 0, 0, 0, 0};

        for (int i = 0; i < 8; i++) wts[i] = DB'(i + 1);
        for (int i = 0; i < 16; i++) fts[i] = DB'(i + 4);
        widx = 0; fidx = 0; wsidx = 0; fsidx = 0; clr_cnt = 0;
        reset_masks();
        drive();

        // Power-on reset
        rst = 1'b0;
        repeat (3) tick();
        check_zero("reset");
        rst = 1'b1;
        tick();

        // 1: single window, cycle-exact table
        start_job(1);
        for (int i = 0; i < 13; i++) begin
            while (cyc < tab[i].c) tick();
            check($sformatf("t1_vec_c%0d", tab[i].c),
                  64'({mac_clear, mac_w_w, mac_w_in, mac_if_w, mac_if_in,
                       res_valid, done, busy, w_ready, f_ready}),
                  64'({tab[i].clr, tab[i].ww, tab[i].wd, tab[i].fw, tab[i].fd,
                       tab[i].rv, tab[i].dn, tab[i].bz, tab[i].wr, tab[i].fr}));
            if (tab[i].c == 10) check("t1_res_data", 64'(res_data), 64'(BASE + 34'd9));
        end
        check_counts("t1_counts", 3, 3, 1);

        // 2: sliding windows
        reset_masks();
        start_job(3);
        while (cyc < 21) begin
            tick();
            check("t2_res_valid", 64'(res_valid), 64'(cyc == 10 || cyc == 14 || cyc == 18));
            check("t2_done", 64'(done), 64'(cyc == 19));
            if (cyc == 14) check("t2_res_data2", 64'(res_data), 64'(BASE + 34'd13));
            if (cyc == 18) check("t2_res_data3", 64'(res_data), 64'(BASE + 34'd17));
            if (cyc == 20) check("t2_busy_low", 64'(busy), 64'd0);
        end
        check_counts("t2_counts", 3, 5, 1);

        // 3: result backpressure for 5 cycles
        reset_masks();
        r_mask[14:10] = 5'b00000;
        start_job(2);
        while (cyc < 21) begin
            tick();
            if (cyc >= 10 && cyc <= 14) begin
                check("t3_hold", 64'({res_valid, f_ready, res_data}), 64'({1'b1, 1'b0, BASE + 34'd9}));
            end
            if (cyc >= 11 && cyc <= 16) check("t3_no_fw", 64'(mac_if_w), 64'd0);
            if (cyc == 16) check("t3_rv_drop", 64'(res_valid), 64'd0);
            if (cyc == 17) check("t3_fw_after", 64'({mac_if_w, mac_if_in}), 64'({1'b1, 16'd7}));
            if (cyc == 19) check("t3_res2", 64'({res_valid, res_data}), 64'({1'b1, BASE + 34'd18}));
            if (cyc == 20) check("t3_done", 64'(done), 64'd1);
        end

        // 4: stream gaps
        wts[0] = 16'hA5A5; wts[1] = 16'hFFFF; wts[2] = 16'h0001;
        for (int i = 0; i < 16; i++) fts[i] = DB'(16'h1000 + 16'(i * 7));
        reset_masks();
        w_mask[7:2] = 6'b101001;
        f_mask = {$urandom, $urandom};
        ww_cycles = '0;
        start_job(2);
        while (!done && cyc < 200) begin
            tick();
            if (cyc < 64) ww_cycles[cyc] = mac_w_w;
            if (cyc == 7) check("t4_w_ready_c7", 64'(w_ready), 64'd1);
            if (cyc == 8) check("t4_w_ready_c8", 64'(w_ready), 64'd0);
        end
        check("t4_done_seen", 64'(done), 64'd1);
        check("t4_ww_cycles", ww_cycles, 64'h148);
        check_counts("t4_counts", 3, 4, 1);
        tick();

        // 5a: zero-window job
        for (int i = 0; i < 8; i++) wts[i] = DB'(i + 1);
        for (int i = 0; i < 16; i++) fts[i] = DB'(i + 4);
        reset_masks();
        start_job(0);
        tick();
        check("t5a_done_c1", 64'({done, busy}), 64'b11);
        tick();
        check("t5a_idle_c2", 64'({done, busy}), 64'b00);
        repeat (3) tick();
        check_counts("t5a_counts", 0, 0, 0);

        // 5b: start pulsed in LOAD_F is ignored
        start_job(1);
        while (cyc < 6) tick();
        start = 1'b1;
        num_win = CW'(5);
        while (cyc < 14) begin
            tick();
            check("t5b_done", 64'(done), 64'(cyc == 11));
            if (cyc >= 12) check("t5b_idle", 64'(busy), 64'd0);
        end
        check_counts("t5b_counts", 3, 3, 1);

        // 6: reset in LOAD_F, then a clean job
        start_job(2);
        while (cyc < 6) tick();
        check("t6_in_load_f", 64'(f_ready), 64'd1);
        rst = 1'b0;
        tick();
        check_zero("t6_reset");
        rst = 1'b1;
        seen_done = 1'b0;
        repeat (3) begin
            tick();
            if (done || busy) seen_done = 1'b1;
        end
        check("t6_no_done", 64'(seen_done), 64'd0);
        start_job(1);
        while (cyc < 12) begin
            tick();
            if (cyc == 1) check("t6_clear", 64'(mac_clear), 64'd1);
            check("t6_done", 64'(done), 64'(cyc == 11));
        end
        check_counts("t6_counts", 3, 3, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
